// File: rtl/oposicao_matriz.sv
`default_nettype none
// ============================================================================
// Module      : oposicao_matriz
// Description : Registered additive inverse of a square signed matrix (2x2..5x5),
//               saturating -MIN to +MAX and flagging it.
// Revision    : 1.0 - initial release
// ============================================================================
module oposicao_matriz #(
  parameter int ELEM_W = 8,
  parameter int MAX_N  = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ELEM_W*MAX_N*MAX_N-1:0]   matrix_A,
  input  logic [1:0]                      matrix_size,
  input  logic                            in_valid,
  output logic [ELEM_W*MAX_N*MAX_N-1:0]   m_oposta_A,
  output logic                            out_valid,
  output logic                            overflow
);

  localparam int c_ELEMS = MAX_N * MAX_N;
  localparam int c_BUS_W = ELEM_W * c_ELEMS;
  localparam logic [ELEM_W-1:0] c_MIN  = {1'b1, {(ELEM_W-1){1'b0}}};
  localparam logic [ELEM_W-1:0] c_MAX  = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] c_ZERO = '0;

  int                  w_n_sq;
  logic [c_ELEMS-1:0]  w_active;
  logic [c_ELEMS-1:0]  w_sat;
  logic [c_BUS_W-1:0]  w_neg;

  logic [c_BUS_W-1:0]  r_result;
  logic                r_valid;
  logic                r_ovf;

  // Active region is the first N*N row-major slots, with row stride N.
  always_comb begin
    w_n_sq = (int'(matrix_size) + 2) * (int'(matrix_size) + 2);
    w_active = '0;
    for (int k = 0; k < c_ELEMS; k++) begin
      w_active[k] = (k < w_n_sq);
    end
  end

  for (genvar k = 0; k < c_ELEMS; k++) begin : g_elem
    logic [ELEM_W-1:0] w_src;
    assign w_src = matrix_A[k*ELEM_W +: ELEM_W];
    assign w_sat[k] = w_active[k] && (w_src == c_MIN);
    // The most negative value has no positive twin; clamp it to +MAX.
    assign w_neg[k*ELEM_W +: ELEM_W] = !w_active[k]     ? c_ZERO :
                                       (w_src == c_MIN) ? c_MAX  :
                                                          c_ZERO - w_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_neg;
        r_ovf    <= |w_sat;
      end
    end
  end

  assign m_oposta_A = r_result;
  assign out_valid  = r_valid;
  assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_oposicao_matriz.sv
`default_nettype none
// ============================================================================
// Module      : tb_oposicao_matriz
// Description : Scoreboard bench for oposicao_matriz (negation, masking, saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oposicao_matriz;

  localparam int c_BUS_W = 200;

  typedef struct {
    logic [c_BUS_W-1:0] data;
    logic               ovf;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [c_BUS_W-1:0] matrix_A = '0;
  logic [1:0]         matrix_size = 2'b00;
  logic               in_valid = 1'b0;
  logic [c_BUS_W-1:0] m_oposta_A;
  logic               out_valid;
  logic               overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t last_exp;

  oposicao_matriz dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .matrix_A   (matrix_A),
    .matrix_size(matrix_size),
    .in_valid   (in_valid),
    .m_oposta_A (m_oposta_A),
    .out_valid  (out_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [c_BUS_W-1:0] obs,
                          input logic [c_BUS_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: integer negation with saturation, zero outside N*N.
  function automatic exp_t model(input logic [c_BUS_W-1:0] a, input logic [1:0] sz);
    exp_t r;
    int   n;
    int   v;
    logic signed [7:0] e;
    r.data = '0;
    r.ovf  = 1'b0;
    n = int'(sz) + 2;
    for (int k = 0; k < n * n; k++) begin
      e = a[8*k +: 8];
      v = -int'(e);
      if (v > 127) begin
        v = 127;
        r.ovf = 1'b1;
      end
      r.data[8*k +: 8] = 8'(v);
    end
    return r;
  endfunction

  task automatic send(input logic [c_BUS_W-1:0] a, input logic [1:0] sz);
    @(negedge clk);
    matrix_A    = a;
    matrix_size = sz;
    in_valid    = 1'b1;
    last_exp    = model(a, sz);
    sb_q.push_back(last_exp);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    matrix_A = {25{8'hA5}};
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_out_valid", 200'(out_valid), 200'(0));
      end else begin
        e = sb_q.pop_front();
        check_eq("result", m_oposta_A, e.data);
        check_eq("overflow", 200'(overflow), 200'(e.ovf));
      end
    end
  end

  initial begin
    logic [c_BUS_W-1:0] a;

    // Asynchronous reset before any clock edge has any effect.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_data", m_oposta_A, '0);
    check_eq("rst_valid", 200'(out_valid), 200'(0));
    check_eq("rst_ovf", 200'(overflow), 200'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 2x2 with garbage in the inactive slots.
    a = {25{8'h55}};
    a[7:0] = 8'd10; a[15:8] = 8'hEC; a[23:16] = 8'd30; a[31:24] = 8'hD8;
    send(a, 2'b00);

    // 3x3: k*5.
    a = {25{8'h33}};
    for (int k = 0; k < 9; k++) a[8*k +: 8] = 8'(k * 5);
    send(a, 2'b01);

    // 5x5: -k.
    for (int k = 0; k < 25; k++) a[8*k +: 8] = 8'(-k);
    send(a, 2'b11);

    // 4x4 boundaries, inactive -128 at slot 16.
    a = {25{8'h11}};
    a[7:0] = 8'h80; a[15:8] = 8'h7F; a[23:16] = 8'h81; a[127:120] = 8'h00;
    a[135:128] = 8'h80;
    send(a, 2'b10);
    idle();
    @(posedge clk); #1;
    check_eq("idle_valid", 200'(out_valid), 200'(0));
    check_eq("idle_hold_slot16", 200'(m_oposta_A[135:128]), 200'(0));

    // Three back-to-back, last one saturates so overflow must be held.
    for (int k = 0; k < 25; k++) a[8*k +: 8] = 8'($urandom_range(0, 255));
    a[7:0] = 8'h01;
    send(a, 2'b11);
    for (int k = 0; k < 25; k++) a[8*k +: 8] = 8'($urandom_range(0, 255));
    a[7:0] = 8'h02;
    send(a, 2'b01);
    for (int k = 0; k < 25; k++) a[8*k +: 8] = 8'($urandom_range(0, 255));
    a[7:0] = 8'h03; a[15:8] = 8'h80;
    send(a, 2'b10);
    idle();
    @(posedge clk); #1;
    check_eq("b2b_end_valid", 200'(out_valid), 200'(0));
    check_eq("b2b_hold_data", m_oposta_A, last_exp.data);
    check_eq("b2b_hold_ovf", 200'(overflow), 200'(1));

    // Mid-cycle asynchronous reset with nonzero outputs.
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_data", m_oposta_A, '0);
    check_eq("midrst_valid", 200'(out_valid), 200'(0));
    check_eq("midrst_ovf", 200'(overflow), 200'(0));
    @(negedge clk) rst_n = 1'b1;
    idle();
    @(posedge clk); #1;
    check_eq("post_rst_valid", 200'(out_valid), 200'(0));

    // First result after reset release; size change between valids.
    a = {25{8'h80}};
    send(a, 2'b00);
    for (int k = 0; k < 25; k++) a[8*k +: 8] = 8'(k + 100);
    send(a, 2'b11);
    idle();
    repeat (3) @(posedge clk);
    #2;
    check_eq("sb_drained", 200'(sb_q.size()), 200'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
